// File: rtl/mem_responder.sv
// mem_responder: memory-side target for the execute unit's bus.
// Each accepted fetch, load or store is routed to the on-chip SRAM, the boot ROM
// overlay or the external IO port. It completes with a one-cycle idone/rdone/wdone
// pulse. Read data is registered and held until the next completion. An IO access
// that is never acknowledged ends with all-ones data and a bus_err pulse.
module mem_responder #(
  parameter int RV         = 32,
  parameter int VA         = RV,
  parameter int SRAM_AW    = 12,
  parameter int ROM_AW     = 10,
  parameter int SRAM_WAIT  = 0,
  parameter int IO_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ifetch,
  input  logic [VA-1:1]        pc,
  input  logic [VA-RV/16-1:0]  addr,
  input  logic [1:0]           rstrobe,
  input  logic [RV/8-1:0]      wmask,
  input  logic [RV-1:0]        wdata,
  input  logic                 io_access,
  input  logic                 rom_enable,
  output logic                 idone,
  output logic                 rdone,
  output logic                 wdone,
  output logic [RV-1:0]        rdata,
  output logic                 sram_en,
  output logic [RV/8-1:0]      sram_we,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [RV-1:0]        sram_wdata,
  input  logic [RV-1:0]        sram_rdata,
  output logic                 rom_en,
  output logic [ROM_AW-1:0]    rom_addr,
  input  logic [RV-1:0]        rom_rdata,
  output logic                 io_req,
  output logic [RV/8-1:0]      io_we,
  output logic [VA-RV/16-1:0]  io_addr,
  output logic [RV-1:0]        io_wdata,
  input  logic                 io_ack,
  input  logic [RV-1:0]        io_rdata,
  output logic                 bus_err
);

  localparam int AW = VA - RV/16;
  localparam int NB = RV/8;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  localparam logic [1:0] T_SRAM = 2'd0;
  localparam logic [1:0] T_ROM  = 2'd1;
  localparam logic [1:0] T_IO   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MEM  = 3'd1,
    S_WAIT = 3'd2,
    S_IO   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      kind_q, kind_d;
  logic [1:0]      tgt_q, tgt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            half_q, half_d;
  logic [1:0]      rstb_q, rstb_d;
  logic [RV-1:0]   wdata_q, wdata_d;
  logic [RV-1:0]   rdata_q, rdata_d;
  logic            idone_q, idone_d, rdone_q, rdone_d, wdone_q, wdone_d;
  logic            bus_err_q, bus_err_d;
  logic            sram_en_q, sram_en_d, rom_en_q, rom_en_d, io_req_q, io_req_d;
  logic [NB-1:0]   sram_we_q, sram_we_d, io_we_q, io_we_d;
  logic            done_s;

  logic            store_req_s, load_req_s, rom_hit_s;
  logic [1:0]      req_kind_s, req_tgt_s;
  logic [AW-1:0]   req_addr_s;

  // Shapes raw memory data: fetch halfword select, byte-load right-justification.
  function automatic logic [RV-1:0] fmt_read(input logic [1:0] kind, input logic half,
                                             input logic [1:0] rstb, input logic [RV-1:0] raw);
    logic [RV-1:0] r;
    if (kind == K_FETCH) begin
      if (RV > 16) begin
        r = (half ? (raw >> 5'd16) : raw) & RV'(16'hFFFF);
      end else begin
        r = raw;
      end
    end else begin
      case (rstb)
        2'b01:   r = raw & RV'(8'hFF);
        2'b10:   r = (raw >> 4'd8) & RV'(8'hFF);
        default: r = raw;
      endcase
    end
    return r;
  endfunction

  // Request decode: stores win over loads, loads over fetches; fetches never go to IO.
  assign store_req_s = (wmask != {NB{1'b0}});
  assign load_req_s  = (rstrobe != 2'b00);
  assign req_kind_s  = store_req_s ? K_STORE : (load_req_s ? K_LOAD : K_FETCH);
  assign req_addr_s  = (store_req_s || load_req_s) ? addr : pc[VA-1:RV/16];
  assign rom_hit_s   = rom_enable && ((req_addr_s >> ROM_AW) == {AW{1'b0}});
  assign req_tgt_s   = ((req_kind_s != K_FETCH) && io_access) ? T_IO :
                       (rom_hit_s ? T_ROM : T_SRAM);

  // State register and all registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      kind_q    <= K_FETCH;
      tgt_q     <= T_SRAM;
      addr_q    <= {AW{1'b0}};
      half_q    <= 1'b0;
      rstb_q    <= 2'b00;
      wdata_q   <= {RV{1'b0}};
      rdata_q   <= {RV{1'b0}};
      idone_q   <= 1'b0;
      rdone_q   <= 1'b0;
      wdone_q   <= 1'b0;
      bus_err_q <= 1'b0;
      sram_en_q <= 1'b0;
      sram_we_q <= {NB{1'b0}};
      rom_en_q  <= 1'b0;
      io_req_q  <= 1'b0;
      io_we_q   <= {NB{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      tgt_q     <= tgt_d;
      addr_q    <= addr_d;
      half_q    <= half_d;
      rstb_q    <= rstb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      idone_q   <= idone_d;
      rdone_q   <= rdone_d;
      wdone_q   <= wdone_d;
      bus_err_q <= bus_err_d;
      sram_en_q <= sram_en_d;
      sram_we_q <= sram_we_d;
      rom_en_q  <= rom_en_d;
      io_req_q  <= io_req_d;
      io_we_q   <= io_we_d;
    end
  end

  // Next-state logic: accept and latch a request, strobe the memory, wait, complete.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    tgt_d     = tgt_q;
    addr_d    = addr_q;
    half_d    = half_q;
    rstb_d    = rstb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    sram_en_d = 1'b0;
    sram_we_d = {NB{1'b0}};
    rom_en_d  = 1'b0;
    io_req_d  = 1'b0;
    io_we_d   = {NB{1'b0}};
    done_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (store_req_s || load_req_s || ifetch) begin
          kind_d  = req_kind_s;
          tgt_d   = req_tgt_s;
          addr_d  = req_addr_s;
          half_d  = pc[1];
          rstb_d  = rstrobe;
          wdata_d = wdata;
          cnt_d   = 8'd0;
          if (req_tgt_s == T_IO) begin
            // wmask is zero for anything but a store, so it doubles as the IO write enable
            state_d  = S_IO;
            io_req_d = 1'b1;
            io_we_d  = wmask;
          end else if (req_tgt_s == T_SRAM) begin
            state_d   = S_MEM;
            sram_en_d = 1'b1;
            sram_we_d = wmask;
          end else begin
            // ROM stores are silently dropped but still walk the normal path to wdone
            state_d  = S_MEM;
            rom_en_d = (req_kind_s != K_STORE);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEM: begin
        state_d = S_WAIT;
        cnt_d   = (tgt_q == T_ROM) ? 8'd0 : 8'(SRAM_WAIT);
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = S_DONE;
          done_s  = 1'b1;
          if (kind_q != K_STORE) begin
            rdata_d = fmt_read(kind_q, half_q, rstb_q, (tgt_q == T_ROM) ? rom_rdata : sram_rdata);
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_IO: begin
        if (io_ack) begin
          state_d = S_DONE;
          done_s  = 1'b1;
          if (kind_q != K_STORE) begin
            rdata_d = fmt_read(kind_q, half_q, rstb_q, io_rdata);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == 8'(IO_TIMEOUT - 1)) begin
          state_d   = S_DONE;
          done_s    = 1'b1;
          rdata_d   = {RV{1'b1}};
          bus_err_d = 1'b1;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          io_req_d = 1'b1;
          io_we_d  = io_we_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    idone_d = done_s && (kind_q == K_FETCH);
    rdone_d = done_s && (kind_q == K_LOAD);
    wdone_d = done_s && (kind_q == K_STORE);
  end

  assign idone      = idone_q;
  assign rdone      = rdone_q;
  assign wdone      = wdone_q;
  assign rdata      = rdata_q;
  assign bus_err    = bus_err_q;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = addr_q[SRAM_AW-1:0];
  assign sram_wdata = wdata_q;
  assign rom_en     = rom_en_q;
  assign rom_addr   = addr_q[ROM_AW-1:0];
  assign io_req     = io_req_q;
  assign io_we      = io_we_q;
  assign io_addr    = addr_q;
  assign io_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (SRAM_WAIT 0 and 3) share stimulus; the idle
// one is held in reset. Expected completions go into a scoreboard queue and a
// monitor pops and compares on every done pulse.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset0, reset1;
  logic        ifetch, io_access, rom_enable, io_ack;
  logic [31:1] pc;
  logic [29:0] addr;
  logic [1:0]  rstrobe;
  logic [3:0]  wmask;
  logic [31:0] wdata, io_rdata;

  logic [1:0]  idone_w, rdone_w, wdone_w, sram_en_w, rom_en_w, io_req_w, bus_err_w;
  logic [31:0] rdata_w [2];
  logic [31:0] sram_wdata_w [2];
  logic [31:0] io_wdata_w [2];
  logic [3:0]  sram_we_w [2];
  logic [3:0]  io_we_w [2];
  logic [11:0] sram_addr_w [2];
  logic [9:0]  rom_addr_w [2];
  logic [29:0] io_addr_w [2];
  logic [31:0] sram_rdata_r [2];
  logic [31:0] rom_rdata_r [2];
  logic [31:0] smem [2][16];

  typedef struct packed {
    logic [7:0]  id;
    logic        dut;
    logic [1:0]  kind;
    logic [31:0] rd;
    logic        berr;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   tid = 0;
  logic s_sram, s_rom, s_io;
  logic [2:0] mon_act;
  exp_t mon_e;

  mem_responder #(.SRAM_WAIT(0), .IO_TIMEOUT(20)) u_dut0 (
    .clk(clk), .reset(reset0), .ifetch(ifetch), .pc(pc), .addr(addr), .rstrobe(rstrobe),
    .wmask(wmask), .wdata(wdata), .io_access(io_access), .rom_enable(rom_enable),
    .idone(idone_w[0]), .rdone(rdone_w[0]), .wdone(wdone_w[0]), .rdata(rdata_w[0]),
    .sram_en(sram_en_w[0]), .sram_we(sram_we_w[0]), .sram_addr(sram_addr_w[0]),
    .sram_wdata(sram_wdata_w[0]), .sram_rdata(sram_rdata_r[0]), .rom_en(rom_en_w[0]),
    .rom_addr(rom_addr_w[0]), .rom_rdata(rom_rdata_r[0]), .io_req(io_req_w[0]),
    .io_we(io_we_w[0]), .io_addr(io_addr_w[0]), .io_wdata(io_wdata_w[0]), .io_ack(io_ack),
    .io_rdata(io_rdata), .bus_err(bus_err_w[0]));

  mem_responder #(.SRAM_WAIT(3), .IO_TIMEOUT(20)) u_dut1 (
    .clk(clk), .reset(reset1), .ifetch(ifetch), .pc(pc), .addr(addr), .rstrobe(rstrobe),
    .wmask(wmask), .wdata(wdata), .io_access(io_access), .rom_enable(rom_enable),
    .idone(idone_w[1]), .rdone(rdone_w[1]), .wdone(wdone_w[1]), .rdata(rdata_w[1]),
    .sram_en(sram_en_w[1]), .sram_we(sram_we_w[1]), .sram_addr(sram_addr_w[1]),
    .sram_wdata(sram_wdata_w[1]), .sram_rdata(sram_rdata_r[1]), .rom_en(rom_en_w[1]),
    .rom_addr(rom_addr_w[1]), .rom_rdata(rom_rdata_r[1]), .io_req(io_req_w[1]),
    .io_we(io_we_w[1]), .io_addr(io_addr_w[1]), .io_wdata(io_wdata_w[1]), .io_ack(io_ack),
    .io_rdata(io_rdata), .bus_err(bus_err_w[1]));

  always #5 clk = ~clk;

  // Cycle counter used for latency expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SRAM and ROM macro models, one pair per instance.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sram_en_w[d]) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we_w[d][b]) smem[d][sram_addr_w[d][3:0]][8*b +: 8] <= sram_wdata_w[d][8*b +: 8];
        end
        sram_rdata_r[d] <= smem[d][sram_addr_w[d][3:0]];
      end
      if (rom_en_w[d]) rom_rdata_r[d] <= 32'hC0DE0000 | {22'd0, rom_addr_w[d]};
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mon_act = {idone_w[d], rdone_w[d], wdone_w[d]};
      if (mon_act != 3'b000 || bus_err_w[d]) begin
        if (sb.size() == 0 || sb[0].dut != d[0]) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done dut%0d: got done=%b bus_err=%b, required none", d, mon_act, bus_err_w[d]);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("t%0d_kind", mon_e.id), {29'd0, mon_act}, {29'd0, 3'b100 >> mon_e.kind});
          check($sformatf("t%0d_cycle", mon_e.id), cyc, mon_e.cyc);
          check($sformatf("t%0d_bus_err", mon_e.id), {31'd0, bus_err_w[d]}, {31'd0, mon_e.berr});
          if (mon_e.kind != 2'd2) check($sformatf("t%0d_rdata", mon_e.id), rdata_w[d], mon_e.rd);
        end
      end
    end
    if (sb.size() != 0 && cyc > int'(sb[0].cyc)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL t%0d_missing_done: got no done by cycle %0d, required at %0d", sb[0].id, cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  // Issue one request for one cycle (at a negedge); kind 0=fetch 1=load 2=store.
  task automatic issue(input int d, input int kind, input logic [29:0] a, input logic hf,
                       input logic [3:0] wm, input logic [31:0] wd, input logic [1:0] rs,
                       input logic [31:0] exp_rd, input int lat, input logic berr, input logic push);
    exp_t en;
    if (push) begin
      en.id = 8'(tid); en.dut = d[0]; en.kind = 2'(kind); en.rd = exp_rd;
      en.berr = berr; en.cyc = 32'(cyc + lat);
      sb.push_back(en);
    end
    tid++;
    ifetch = (kind == 0); pc = {a, hf}; addr = a; rstrobe = rs; wmask = wm; wdata = wd;
    @(negedge clk);
    ifetch = 1'b0; rstrobe = 2'b00; wmask = 4'b0000;
    s_sram = sram_en_w[d]; s_rom = rom_en_w[d]; s_io = io_req_w[d];
  endtask

  task automatic wait_idle();
    int g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: got %0d pending, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) smem[d][i] = 32'd0;
    reset0 = 1'b0; reset1 = 1'b0; ifetch = 1'b0; io_access = 1'b0; rom_enable = 1'b0;
    io_ack = 1'b0; pc = '0; addr = 30'd0; rstrobe = 2'b00; wmask = 4'b0000;
    wdata = 32'd0; io_rdata = 32'd0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_dones", {28'd0, idone_w[d], rdone_w[d], wdone_w[d], bus_err_w[d]}, 32'd0);
      check("rst_strobes", {29'd0, io_req_w[d], sram_en_w[d], rom_en_w[d]}, 32'd0);
      check("rst_rdata", rdata_w[d], 32'd0);
    end
    reset0 = 1'b1;
    @(negedge clk);

    // SRAM store / load round trip, SRAM_WAIT=0
    issue(0, 2, 30'd5, 1'b0, 4'b1111, 32'hDEADBEEF, 2'b00, 32'd0, 3, 1'b0, 1'b1);
    check("st_sram_en", {31'd0, s_sram}, 32'd1);
    check("st_sram_we", {28'd0, sram_we_w[0]}, 32'hF);
    wait_idle();
    issue(0, 1, 30'd5, 1'b0, 4'b0000, 32'd0, 2'b11, 32'hDEADBEEF, 3, 1'b0, 1'b1);
    wait_idle();
    issue(0, 2, 30'd6, 1'b0, 4'b1111, 32'h1234ABCD, 2'b00, 32'd0, 3, 1'b0, 1'b1);
    wait_idle();
    issue(0, 1, 30'd6, 1'b0, 4'b0000, 32'd0, 2'b10, 32'h000000AB, 3, 1'b0, 1'b1);
    wait_idle();
    issue(0, 1, 30'd6, 1'b0, 4'b0000, 32'd0, 2'b01, 32'h000000CD, 3, 1'b0, 1'b1);
    wait_idle();

    // ROM overlay: load, dropped store, and the first address past the window
    rom_enable = 1'b1;
    issue(0, 1, 30'd3, 1'b0, 4'b0000, 32'd0, 2'b11, 32'hC0DE0003, 3, 1'b0, 1'b1);
    check("rom_ld_rom_en", {30'd0, s_rom, s_sram}, 32'd2);
    wait_idle();
    issue(0, 2, 30'd3, 1'b0, 4'b1111, 32'h99999999, 2'b00, 32'd0, 3, 1'b0, 1'b1);
    check("rom_st_no_strobe", {30'd0, s_rom, s_sram}, 32'd0);
    wait_idle();
    issue(0, 1, 30'd1023, 1'b0, 4'b0000, 32'd0, 2'b11, 32'hC0DE03FF, 3, 1'b0, 1'b1);
    wait_idle();
    issue(0, 2, 30'd1024, 1'b0, 4'b1111, 32'h5A5A0400, 2'b00, 32'd0, 3, 1'b0, 1'b1);
    check("rom_edge_sram", {30'd0, s_rom, s_sram}, 32'd1);
    wait_idle();
    issue(0, 1, 30'd1024, 1'b0, 4'b0000, 32'd0, 2'b11, 32'h5A5A0400, 3, 1'b0, 1'b1);
    wait_idle();
    rom_enable = 1'b0;
    issue(0, 1, 30'd3, 1'b0, 4'b0000, 32'd0, 2'b11, 32'h00000000, 3, 1'b0, 1'b1);
    wait_idle();

    // Fetch halfword select; io_access must not divert a fetch
    issue(0, 2, 30'd8, 1'b0, 4'b1111, 32'hAAAA5555, 2'b00, 32'd0, 3, 1'b0, 1'b1);
    wait_idle();
    issue(0, 0, 30'd8, 1'b1, 4'b0000, 32'd0, 2'b00, 32'h0000AAAA, 3, 1'b0, 1'b1);
    wait_idle();
    io_access = 1'b1;
    issue(0, 0, 30'd8, 1'b0, 4'b0000, 32'd0, 2'b00, 32'h00005555, 3, 1'b0, 1'b1);
    check("fetch_not_io", {30'd0, s_io, s_sram}, 32'd1);
    wait_idle();

    // IO read acknowledged after 4 cycles
    issue(0, 1, 30'h77, 1'b0, 4'b0000, 32'd0, 2'b11, 32'h00000007, 5, 1'b0, 1'b1);
    check("io_rd_req", {31'd0, s_io}, 32'd1);
    check("io_rd_addr", {2'd0, io_addr_w[0]}, 32'h77);
    check("io_rd_we", {28'd0, io_we_w[0]}, 32'd0);
    repeat (3) @(negedge clk);
    check("io_rd_req_held", {31'd0, io_req_w[0]}, 32'd1);
    io_ack = 1'b1; io_rdata = 32'd7;
    @(negedge clk);
    io_ack = 1'b0; io_rdata = 32'd0;
    wait_idle();
    check("io_rd_req_drop", {31'd0, io_req_w[0]}, 32'd0);

    // IO store acknowledged immediately
    issue(0, 2, 30'h40, 1'b0, 4'b0011, 32'h11223344, 2'b00, 32'd0, 2, 1'b0, 1'b1);
    check("io_wr_we", {28'd0, io_we_w[0]}, 32'h3);
    check("io_wr_data", io_wdata_w[0], 32'h11223344);
    io_ack = 1'b1;
    @(negedge clk);
    io_ack = 1'b0;
    wait_idle();

    // IO timeout, then a late ack that must be ignored
    issue(0, 1, 30'h55, 1'b0, 4'b0000, 32'd0, 2'b11, 32'hFFFFFFFF, 21, 1'b1, 1'b1);
    wait_idle();
    check("to_req_drop", {31'd0, io_req_w[0]}, 32'd0);
    io_ack = 1'b1; io_rdata = 32'h12345678;
    @(negedge clk);
    io_ack = 1'b0; io_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("to_rdata_held", rdata_w[0], 32'hFFFFFFFF);

    // Reset in the middle of an IO access
    issue(0, 1, 30'h66, 1'b0, 4'b0000, 32'd0, 2'b11, 32'd0, 0, 1'b0, 1'b0);
    check("rstio_req", {31'd0, s_io}, 32'd1);
    reset0 = 1'b0;
    @(negedge clk);
    check("rstio_req_drop", {31'd0, io_req_w[0]}, 32'd0);
    check("rstio_rdata", rdata_w[0], 32'd0);
    reset0 = 1'b1; io_access = 1'b0;
    repeat (4) @(negedge clk);
    issue(0, 1, 30'd5, 1'b0, 4'b0000, 32'd0, 2'b11, 32'hDEADBEEF, 3, 1'b0, 1'b1);
    wait_idle();

    // Second instance, SRAM_WAIT=3
    reset0 = 1'b0; reset1 = 1'b1;
    @(negedge clk);
    issue(1, 2, 30'd2, 1'b0, 4'b1111, 32'hAAAA5555, 2'b00, 32'd0, 6, 1'b0, 1'b1);
    wait_idle();
    issue(1, 0, 30'd2, 1'b1, 4'b0000, 32'd0, 2'b00, 32'h0000AAAA, 6, 1'b0, 1'b1);
    wait_idle();
    issue(1, 1, 30'd2, 1'b0, 4'b0000, 32'd0, 2'b11, 32'hAAAA5555, 6, 1'b0, 1'b1);
    wait_idle();

    // Reset during WAIT: no completion, next request normal
    issue(1, 1, 30'd2, 1'b0, 4'b0000, 32'd0, 2'b11, 32'd0, 0, 1'b0, 1'b0);
    check("rstw_sram_en", {31'd0, s_sram}, 32'd1);
    @(negedge clk);
    reset1 = 1'b0;
    @(negedge clk);
    reset1 = 1'b1;
    repeat (6) @(negedge clk);
    issue(1, 1, 30'd2, 1'b0, 4'b0000, 32'd0, 2'b01, 32'h00000055, 6, 1'b0, 1'b1);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
